// File: rtl/mixer_iq_param.sv
// rtl/mixer_iq_param.sv - parametrised 1-bit x multi-bit I/Q mixer
//
// Purpose: multiplies the synchronised sigma-delta comparator bit (+1/-1) by
// signed NCO sine/cosine samples. Each product is MSB-aligned into OUT_W bits,
// registered when ce is high, and then passed through OUT_PIPE output stages.
//
// Optional feature: define MIXER_RF_DENSITY_EN to count the ones in each window
// of 2^WIN_LOG2 ce-qualified samples.
//
// Ports:
//   i_clk           system clock
//   i_rst           asynchronous active-high reset
//   i_ce            sample qualifier for i_sin_in / i_cos_in
//   i_rf_in         raw asynchronous comparator bit
//   i_sin_in        signed LO sine sample   (LO_W)
//   i_cos_in        signed LO cosine sample (LO_W)
//   o_rf_out        synchronised RF bit, fed back to the comparator DAC
//   o_mix_sin       signed I product (OUT_W)
//   o_mix_cos       signed Q product (OUT_W)
//   o_mix_valid     qualifies o_mix_sin / o_mix_cos
//   o_rf_density    ones in the last window (WIN_LOG2+1)
//   o_density_valid one-cycle pulse when o_rf_density updates
module mixer_iq_param #(
  parameter int LO_W        = 8,
  parameter int OUT_W       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_PIPE    = 1,
  parameter int WIN_LOG2    = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ce,
  input  logic                    i_rf_in,
  input  logic signed [LO_W-1:0]  i_sin_in,
  input  logic signed [LO_W-1:0]  i_cos_in,
  output logic                    o_rf_out,
  output logic signed [OUT_W-1:0] o_mix_sin,
  output logic signed [OUT_W-1:0] o_mix_cos,
  output logic                    o_mix_valid,
  output logic [WIN_LOG2:0]       o_rf_density,
  output logic                    o_density_valid
);

  localparam int SHIFT = OUT_W - LO_W;
  localparam logic signed [LO_W-1:0] LO_MIN = {1'b1, {(LO_W-1){1'b0}}};
  localparam logic signed [LO_W-1:0] LO_MAX = {1'b0, {(LO_W-1){1'b1}}};

  // Sign the LO sample by the RF bit. Negating the most-negative code has no
  // positive counterpart, so it clamps to full-scale positive.
  function automatic logic signed [LO_W-1:0] f_apply_sign(
    input logic signed [LO_W-1:0] lo,
    input logic                   pos
  );
    if (pos)
      return lo;
    else if (lo == LO_MIN)
      return LO_MAX;
    else
      return -lo;
  endfunction

  // Synchroniser: resets to 1 so the mixer starts in the +lo polarity.
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_sync <= '1;
    else
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rf_in};
  end

  assign o_rf_out = r_sync[SYNC_STAGES-1];

  logic signed [LO_W-1:0]  w_p_sin;
  logic signed [LO_W-1:0]  w_p_cos;
  logic signed [OUT_W-1:0] w_ext_sin;
  logic signed [OUT_W-1:0] w_ext_cos;

  assign w_p_sin   = f_apply_sign(i_sin_in, o_rf_out);
  assign w_p_cos   = f_apply_sign(i_cos_in, o_rf_out);
  // Sign-extend first, then shift, so LO full scale maps to output full scale.
  assign w_ext_sin = OUT_W'(w_p_sin) <<< SHIFT;
  assign w_ext_cos = OUT_W'(w_p_cos) <<< SHIFT;

  logic signed [OUT_W-1:0] r_prod_sin;
  logic signed [OUT_W-1:0] r_prod_cos;
  logic                    r_prod_vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prod_sin <= '0;
      r_prod_cos <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_prod_vld <= i_ce;
      if (i_ce) begin
        r_prod_sin <= w_ext_sin;
        r_prod_cos <= w_ext_cos;
      end
    end
  end

  generate
    if (OUT_PIPE == 0) begin : g_nopipe
      assign o_mix_sin   = r_prod_sin;
      assign o_mix_cos   = r_prod_cos;
      assign o_mix_valid = r_prod_vld;
    end else begin : g_pipe
      logic signed [OUT_W-1:0] r_pipe_sin [OUT_PIPE];
      logic signed [OUT_W-1:0] r_pipe_cos [OUT_PIPE];
      logic                    r_pipe_vld [OUT_PIPE];

      // Free-running shift: data and valid stay aligned and ignore ce.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < OUT_PIPE; i++) begin
            r_pipe_sin[i] <= '0;
            r_pipe_cos[i] <= '0;
            r_pipe_vld[i] <= 1'b0;
          end
        end else begin
          r_pipe_sin[0] <= r_prod_sin;
          r_pipe_cos[0] <= r_prod_cos;
          r_pipe_vld[0] <= r_prod_vld;
          for (int i = 1; i < OUT_PIPE; i++) begin
            r_pipe_sin[i] <= r_pipe_sin[i-1];
            r_pipe_cos[i] <= r_pipe_cos[i-1];
            r_pipe_vld[i] <= r_pipe_vld[i-1];
          end
        end
      end

      assign o_mix_sin   = r_pipe_sin[OUT_PIPE-1];
      assign o_mix_cos   = r_pipe_cos[OUT_PIPE-1];
      assign o_mix_valid = r_pipe_vld[OUT_PIPE-1];
    end
  endgenerate

`ifdef MIXER_RF_DENSITY_EN
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [WIN_LOG2:0]   r_ones;
  logic [WIN_LOG2:0]   w_ones_next;

  assign w_ones_next = r_ones + {{WIN_LOG2{1'b0}}, o_rf_out};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_win_cnt       <= '0;
      r_ones          <= '0;
      o_rf_density    <= '0;
      o_density_valid <= 1'b0;
    end else begin
      o_density_valid <= 1'b0;
      if (i_ce) begin
        // The last sample of the window is included in the published total.
        if (r_win_cnt == '1) begin
          o_rf_density    <= w_ones_next;
          o_density_valid <= 1'b1;
          r_win_cnt       <= '0;
          r_ones          <= '0;
        end else begin
          r_win_cnt <= r_win_cnt + 1'b1;
          r_ones    <= w_ones_next;
        end
      end
    end
  end
`else
  assign o_rf_density    = '0;
  assign o_density_valid = 1'b0;
`endif

endmodule

// File: doc/mixer_iq_param.md
Name: mixer_iq_param

Overview:
- Parametrised I/Q mixer for the 1-bit sigma-delta RF front end; the next generation of the team's fixed ±127 mixer.
- Multiplies the synchronised 1-bit comparator stream (±1) by multi-bit signed sine/cosine LO samples from the NCO.
- Produces MSB-aligned signed I/Q products, with a valid strobe and a configurable output pipeline.
- Sits between the comparator/NCO and the CIC decimators.

Parameters:
- LO_W, 8: signed LO sample width, 2..16.
- OUT_W, 12: signed product width; must be >= LO_W.
- SYNC_STAGES, 2: rf_in synchroniser depth, 2..4.
- OUT_PIPE, 1: extra output register stages after the product register, 0..3.
- WIN_LOG2, 10: density window is 2^WIN_LOG2 samples; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ce  in  1  sample qualifier; marks sin_in/cos_in valid this cycle.
- rf_in  in  1  raw comparator bit (asynchronous).
- sin_in  in  LO_W  signed LO sine sample.
- cos_in  in  LO_W  signed LO cosine sample.
- rf_out  out  1  synchronised RF bit, fed back to the comparator DAC.
- mix_sin  out  OUT_W  signed I product.
- mix_cos  out  OUT_W  signed Q product.
- mix_valid  out  1  qualifies mix_sin/mix_cos.
- rf_density  out  WIN_LOG2+1  count of ones in the last window.
- density_valid  out  1  one-cycle pulse when rf_density updates.

Behaviour:
- Reset, asynchronous active-high, effective immediately, including mid-operation:
  - Synchroniser flops and rf_out = 1.
  - mix_sin, mix_cos and every pipeline stage = 0.
  - mix_valid = 0; valid pipeline = 0.
  - Density counter, window counter, rf_density and density_valid = 0.
- Synchroniser: shifts every cycle regardless of ce; rf_out is the last stage.
- Product register:
  - Updates only when ce = 1; otherwise holds its previous value.
  - Valid bit of this stage = ce, registered every cycle.
- Product rule:
  - rf_out = 1 → p = +lo.
  - rf_out = 0 → p = −lo.
  - Negating the most-negative LO value saturates to 2^(LO_W−1)−1; no wrap.
  - Result = p sign-extended, then shifted left by OUT_W−LO_W (MSB-aligned, full scale preserved).
  - I uses sin_in, Q uses cos_in; both use the same rf_out sample.
- Output pipeline:
  - OUT_PIPE stages shift every cycle; data and valid travel together.
  - OUT_PIPE = 0 → outputs come directly from the product register.
- Latency:
  - sin_in/cos_in/ce → outputs: 1+OUT_PIPE cycles.
  - rf_in → sign change at outputs: SYNC_STAGES+1+OUT_PIPE cycles (with ce held 1).
- ce low: mix_valid goes 0 at the matching latency. Data outputs keep shifting, so stale held product values appear with valid = 0; the bench must not check data while valid = 0.
- No backpressure: downstream must accept every valid sample.

Optional Feature:
- Macro: MIXER_RF_DENSITY_EN.
- Defined:
  - On each ce = 1 cycle, the window counter increments and the ones counter adds rf_out.
  - On the 2^WIN_LOG2-th sample, rf_density loads the total including that sample (range 0..2^WIN_LOG2) and density_valid pulses high for one cycle.
  - Both counters restart at 0 on that same cycle.
  - ce = 0 freezes both counters.
- Undefined: rf_density and density_valid are tied to 0; no counter logic is generated.

Test Plan:
(LO_W=8, OUT_W=12, SYNC_STAGES=2, OUT_PIPE=1, WIN_LOG2=4)
1. Assert rst mid-stream with random inputs → same cycle: rf_out=1, mix_sin=mix_cos=0, mix_valid=0, rf_density=0.
2. rf_in=1 held, ce=1, sin=+100, cos=−50 → after 2 cycles: mix_sin=+1600, mix_cos=−800, mix_valid=1.
3. Step rf_in 1→0 with LO constant → 4 cycles later: mix_sin=−1600, mix_cos=+800; no earlier change.
4. rf=0, sin=−128, cos=+127 → mix_sin=+2032 (saturated), mix_cos=−2032.
5. ce pattern 1,0,0,1 → mix_valid shows 1,0,0,1 delayed by 2 cycles; data on valid cycles matches the samples taken when ce=1.
6. With MIXER_RF_DENSITY_EN: rf alternating 1/0, ce=1 → rf_density=8 with density_valid pulsing every 16 cycles. rf held 1 → 16. Inserting ce=0 gaps delays the pulse by the gap length.
